// File: rtl/cic_integ_decim.sv
// -----------------------------------------------------------------------------
// cic_integ_decim
//
// Integrator and decimator half of a CIC decimation filter. Each accepted
// input sample (val_in=1) is sign-extended to the full CIC growth width and
// pushed through N cascaded integrators. The integrators form a pipelined
// chain: stage k accumulates the registered (pre-edge) value of stage k-1, so
// an impulse reaches the last stage after N accepted samples. Every R-th
// accepted sample (R = 2**RLOG) the new value of the last integrator is
// captured into data_out and val_out pulses for one cycle. The downstream
// comb stage consumes every pulse; there is no backpressure.
//
// All arithmetic is Wout-bit two's complement and wraps on overflow. The
// wrap is intentional: the comb stage that follows undoes it exactly as long
// as Wout covers the full CIC bit growth.
//
// Parameters:
//   Win   input sample width (signed)
//   N     number of integrator stages (1..6)
//   RLOG  log2 of the decimation factor (1..6)
//   Wout  derived output/internal width, Win + N*RLOG
//
// Ports:
//   clk       system clock, rising-edge active
//   rst       asynchronous active-low reset; clears all state immediately
//   data_in   signed input sample, qualified by val_in
//   val_in    input sample strobe, gaps allowed
//   data_out  signed decimated integrator output, held between pulses
//   val_out   one-cycle pulse marking a new data_out
// -----------------------------------------------------------------------------
module cic_integ_decim #(
    parameter int  Win  = 16,
    parameter int  N    = 3,
    parameter int  RLOG = 3,
    localparam int Wout = Win + N * RLOG
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [Win-1:0]  data_in,
    input  logic                   val_in,
    output logic signed [Wout-1:0] data_out,
    output logic                   val_out
);

    // -------------------------------------------------------------------------
    // Integrator chain
    // -------------------------------------------------------------------------
    logic signed [Wout-1:0] integ_q  [N];
    logic signed [Wout-1:0] integ_d  [N];
    logic signed [Wout-1:0] stage_in [N];

    // Full-width sign extension of the input sample.
    logic signed [Wout-1:0] data_in_ext;
    assign data_in_ext = {{(Wout - Win){data_in[Win-1]}}, data_in};

    // Stage 0 integrates the input sample; every later stage integrates the
    // registered output of its predecessor. Using the registered value (not
    // the predecessor's next value) is what gives the one-sample skew per
    // stage and keeps each adder on a single-adder-deep path.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : gen_stage
            if (gi == 0) begin : gen_first
                assign stage_in[gi] = data_in_ext;
            end else begin : gen_rest
                assign stage_in[gi] = integ_q[gi-1];
            end
            // Modular add: overflow wraps silently by design.
            assign integ_d[gi] = integ_q[gi] + stage_in[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                integ_q[i] <= '0;
            end
        end else if (val_in) begin
            for (int i = 0; i < N; i++) begin
                integ_q[i] <= integ_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Decimation counter
    // -------------------------------------------------------------------------
    // R is a power of two, so an RLOG-bit counter wraps from R-1 back to 0
    // on its own and "last sample of the block" is simply all ones.
    logic [RLOG-1:0] cnt_q;
    logic [RLOG-1:0] cnt_d;
    logic            cnt_last;

    assign cnt_last = (cnt_q == {RLOG{1'b1}});
    assign cnt_d    = cnt_q + RLOG'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (val_in) begin
            cnt_q <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Decimated output register
    // -------------------------------------------------------------------------
    // The output takes the last stage's *next* value so the sample accepted
    // on this edge is already included in the decimated result.
    logic                   take_out;
    logic signed [Wout-1:0] data_out_q;
    logic                   val_out_q;

    assign take_out = val_in && cnt_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_q <= '0;
            val_out_q  <= 1'b0;
        end else begin
            val_out_q <= take_out;
            if (take_out) begin
                data_out_q <= integ_d[N-1];
            end
        end
    end

    assign data_out = data_out_q;
    assign val_out  = val_out_q;

endmodule

// File: doc/cic_integ_decim.md
Name: cic_integ_decim

Overview:
- Integrator-plus-decimator front half of a CIC decimation filter.
- Accepts one signed sample per val_in cycle and runs it through N cascaded, pipelined integrators.
- Passes every R-th integrator output downstream with a one-cycle val_out pulse.
- Sits upstream of the comb stage: its data_out/val_out drive the comb's data_in/val_in through the same valid-qualified streaming interface.

Parameters:
- Win, 16, input sample width (signed two's complement).
- N, 3, number of cascaded integrator stages (1..6).
- RLOG, 3, log2 of decimation factor; R = 2**RLOG (RLOG 1..6).
- Wout (localparam), Win + N*RLOG, internal and output width (CIC growth, M=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; clears all state immediately.
- data_in  input  Win  signed input sample, valid when val_in=1.
- val_in  input  1  input sample strobe; any duty cycle, gaps allowed.
- data_out  output  Wout  signed decimated integrator output.
- val_out  output  1  one-cycle pulse marking a new data_out.

Behaviour:
- Reset (rst=0, async):
  - Integrators I1..IN = 0, decimation counter cnt = 0.
  - data_out = 0, val_out = 0.
  - Deassertion is taken synchronously; first sample is accepted on the first rising edge with rst=1.
- Integrator update, only on cycles with val_in=1:
  - I1 <= I1 + sext(data_in).
  - Ik <= Ik + I(k-1) for k=2..N, using pre-edge (registered) values, i.e. a pipelined chain.
  - All sums are Wout bits with modular two's-complement wrap. No saturation: wrap is required for CIC correctness.
- val_in=0: integrators, cnt and data_out hold. val_out=0 the following cycle.
- Decimation counter:
  - cnt increments 0..R-1 on each val_in=1 cycle and wraps to 0 after R-1.
  - When val_in=1 and cnt==R-1, at the same edge: data_out <= the new IN value (IN + I(N-1)), val_out <= 1.
  - Otherwise val_out <= 0.
- Latency: val_out asserts the cycle after the R-th accepted sample. val_out never stays high for two consecutive cycles (R>=2).
- data_out holds its value between pulses.
- The downstream comb consumes every pulse. There is no backpressure; the block never stalls.
- Input impulse response: a sample at accepted index 0 first reaches IN after N accepted samples, due to pipeline skew. Decimation phase is fixed by cnt, not by data.
- Reset mid-operation: all state is lost and cnt restarts at 0. The next val_out comes R accepted samples after reset release. No partial-block output.
- Simultaneous rst=0 and val_in=1: reset wins, the sample is discarded.

Test Plan:
- Reset: hold rst=0 for 10 cycles with val_in toggling -> data_out=0, val_out=0 throughout. First rising edge after release accepts data.
- Impulse (Win=16, N=3, RLOG=3): data_in=1 on sample 0, then 0, val_in=1 continuous -> val_out pulses 1 cycle after samples 7, 15, 23. data_out = 21, 105, 253 (IN after sample k = (k-1)k/2).
- Negative impulse: data_in=-1 (16'hFFFF) then zeros -> data_out = -21, -105 (25'h1FFFFEB, 25'h1FFFF97). Confirms sign extension.
- Gapped input: repeat the impulse test with val_in high every third cycle -> identical data_out sequence 21, 105, 253. val_out only follows the 8th, 16th and 24th accepted samples. State holds during gaps.
- Wrap-around: data_in=32767 constant for 2000 samples -> every data_out equals a Wout-bit modular reference model, bit-exact, with no saturation.
- Mid-stream reset: impulse, then rst=0 for 1 cycle after sample 5 (before first output) -> no val_out pulse. A fresh impulse after release gives data_out=21 after its 8th sample.
